// File: rtl/dvfs_sequencer.sv
// DVFS sequencer: orders regulator and clock-divider changes so the clock
// never outruns the rail. Raising: voltage first, then frequency once the
// rail has settled. Lowering: frequency first, then voltage after a fixed wait.
// Also watches the rail for undervoltage while idle.
//
// state    | meaning
// IDLE     | ready for a request; undervoltage monitor active
// WAIT_V   | vdd_sel raised, waiting for the rail to settle or time out
// F_SETTLE | freq_sel lowered, waiting before dropping vdd_sel
// FINISH   | transition committed; done pulses for this one cycle
module dvfs_sequencer #(
  parameter logic [15:0] TH0           = 16'h2000,
  parameter logic [15:0] TH1           = 16'h3000,
  parameter logic [15:0] TH2           = 16'h4000,
  parameter logic [15:0] TH3           = 16'h5000,
  parameter int          STABLE_CYCLES = 4,
  parameter int          FREQ_SETTLE   = 8,
  parameter int          TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_level,
  output logic        req_ready,
  input  logic [15:0] voltage_adc,
  output logic [1:0]  vdd_sel,
  output logic [1:0]  freq_sel,
  output logic [1:0]  cur_level,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        uv_alarm
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STABLE_C  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_C  = CW'(FREQ_SETTLE);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_V, F_SETTLE, FINISH} state_t;

  state_t        state_q;
  logic [1:0]    tgt_q, vdd_q, freq_q, cur_q;
  logic          done_q, err_q, uv_q;
  logic [CW-1:0] stab_q, settle_q, tmo_q, uv_cnt_q;
  logic [CW-1:0] stab_d, settle_d, tmo_d, uv_cnt_d;
  logic          tgt_in_range, cur_low;

  function automatic logic [15:0] th_of(input logic [1:0] lvl);
    logic [15:0] th;
    case (lvl)
      2'd0:    th = TH0;
      2'd1:    th = TH1;
      2'd2:    th = TH2;
      default: th = TH3;
    endcase
    return th;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // Next counter values; the FSM decides which ones to commit.
  always_comb begin
    tgt_in_range = (voltage_adc >= th_of(tgt_q));
    cur_low      = (voltage_adc <  th_of(cur_q));
    stab_d       = tgt_in_range ? sat_inc(stab_q) : '0;
    settle_d     = sat_inc(settle_q);
    tmo_d        = sat_inc(tmo_q);
    uv_cnt_d     = cur_low ? sat_inc(uv_cnt_q) : '0;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      vdd_q    <= '0;
      freq_q   <= '0;
      cur_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      uv_q     <= 1'b0;
      stab_q   <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
      uv_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            tgt_q    <= req_level;
            err_q    <= 1'b0;
            stab_q   <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            uv_cnt_q <= '0;
            uv_q     <= 1'b0;
            if (req_level == cur_q) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else if (req_level > cur_q) begin
              vdd_q   <= req_level;
              state_q <= WAIT_V;
            end else begin
              freq_q  <= req_level;
              state_q <= F_SETTLE;
            end
          end else begin
            uv_cnt_q <= uv_cnt_d;
            uv_q     <= (uv_cnt_d >= STABLE_C);
          end
        end
        WAIT_V: begin
          stab_q <= stab_d;
          tmo_q  <= tmo_d;
          // Settling wins over a timeout landing on the same cycle.
          if (stab_d >= STABLE_C) begin
            freq_q  <= tgt_q;
            cur_q   <= tgt_q;
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else if (tmo_d >= TIMEOUT_C) begin
            vdd_q   <= cur_q;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        F_SETTLE: begin
          // vdd drops on the last settle cycle; FINISH follows one cycle later.
          if (settle_q >= SETTLE_C) begin
            vdd_q   <= tgt_q;
            cur_q   <= tgt_q;
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            settle_q <= settle_d;
            if (settle_d >= SETTLE_C) begin
              vdd_q <= tgt_q;
              cur_q <= tgt_q;
            end
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = ~req_ready;
  assign vdd_sel     = vdd_q;
  assign freq_sel    = freq_q;
  assign cur_level   = cur_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign uv_alarm    = uv_q;

endmodule

// File: tb/tb_dvfs_sequencer.sv
// Directed bench for dvfs_sequencer: a per-cycle vector table for the basic
// raise/lower/undervoltage flows, plus hand sequences for timeout, busy
// request blocking and reset during a lowering transition.
module tb_dvfs_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_level = 2'd0;
  logic [15:0] voltage_adc = 16'h0000;
  logic        req_ready, busy, done, err_timeout, uv_alarm;
  logic [1:0]  vdd_sel, freq_sel, cur_level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  lvl;
    logic [15:0] adc;
    logic [1:0]  vdd;
    logic [1:0]  freq;
    logic [1:0]  cur;
    logic        busy;
    logic        done;
    logic        err;
    logic        uv;
  } vec_t;

  vec_t vecs[$];

  dvfs_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_level   (req_level),
    .req_ready   (req_ready),
    .voltage_adc (voltage_adc),
    .vdd_sel     (vdd_sel),
    .freq_sel    (freq_sel),
    .cur_level   (cur_level),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .uv_alarm    (uv_alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // freq_sel must never exceed vdd_sel.
  always @(negedge clk) begin
    if (!$isunknown({freq_sel, vdd_sel})) begin
      checks++;
      if (freq_sel > vdd_sel) begin
        errors++;
        $display("FAIL freq_le_vdd: freq_sel %0d vdd_sel %0d", freq_sel, vdd_sel);
      end
    end
  end

  function automatic void add(input int r, input int v, input int l, input int a,
                              input int ev, input int ef, input int ec,
                              input int eb, input int ed, input int ee, input int eu);
    vec_t t;
    t.rst  = 1'(r);
    t.vld  = 1'(v);
    t.lvl  = 2'(l);
    t.adc  = 16'(a);
    t.vdd  = 2'(ev);
    t.freq = 2'(ef);
    t.cur  = 2'(ec);
    t.busy = 1'(eb);
    t.done = 1'(ed);
    t.err  = 1'(ee);
    t.uv   = 1'(eu);
    vecs.push_back(t);
  endfunction

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input int r, input int v, input int l, input int a);
    @(negedge clk);
    rst         = 1'(r);
    req_valid   = 1'(v);
    req_level   = 2'(l);
    voltage_adc = 16'(a);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   end_n;
    int   done_n;
    logic done_seen;
    logic vdd_bad;
    logic busy_seen;

    // Raise 0 -> 2 with the rail already in range.
    add(1, 0, 0, 'h4800, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 'h4800, 2, 0, 0, 1, 0, 0, 0);
    repeat (3) add(0, 0, 0, 'h4800, 2, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 'h4800, 2, 2, 2, 1, 1, 0, 0);
    add(0, 0, 0, 'h4800, 2, 2, 2, 0, 0, 0, 0);
    // Lower 2 -> 0.
    add(0, 1, 0, 'h4800, 2, 0, 2, 1, 0, 0, 0);
    repeat (7) add(0, 0, 0, 'h4800, 2, 0, 2, 1, 0, 0, 0);
    add(0, 0, 0, 'h4800, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 'h4800, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 'h4800, 0, 0, 0, 0, 0, 0, 0);
    // Raise 0 -> 1.
    add(0, 1, 1, 'h3100, 1, 0, 0, 1, 0, 0, 0);
    repeat (3) add(0, 0, 0, 'h3100, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 'h3100, 1, 1, 1, 1, 1, 0, 0);
    add(0, 0, 0, 'h3100, 1, 1, 1, 0, 0, 0, 0);
    // Undervoltage at level 1: alarm after 4 low samples, clears on 16'h3000.
    repeat (3) add(0, 0, 0, 'h2F00, 1, 1, 1, 0, 0, 0, 0);
    repeat (2) add(0, 0, 0, 'h2F00, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 'h3000, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 'h3000, 1, 1, 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].vld, vecs[i].lvl, vecs[i].adc);
      chk($sformatf("row%0d vdd_sel", i),     16'(vdd_sel),     16'(vecs[i].vdd));
      chk($sformatf("row%0d freq_sel", i),    16'(freq_sel),    16'(vecs[i].freq));
      chk($sformatf("row%0d cur_level", i),   16'(cur_level),   16'(vecs[i].cur));
      chk($sformatf("row%0d busy", i),        16'(busy),        16'(vecs[i].busy));
      chk($sformatf("row%0d req_ready", i),   16'(req_ready),   16'(!vecs[i].busy));
      chk($sformatf("row%0d done", i),        16'(done),        16'(vecs[i].done));
      chk($sformatf("row%0d err_timeout", i), 16'(err_timeout), 16'(vecs[i].err));
      chk($sformatf("row%0d uv_alarm", i),    16'(uv_alarm),    16'(vecs[i].uv));
    end

    // Raise 1 -> 3 with the rail toggling in/out of range every 2 cycles.
    cyc(0, 1, 3, 'h5100);
    chk("tmo accept vdd_sel", 16'(vdd_sel), 16'd3);
    chk("tmo accept busy", 16'(busy), 16'd1);
    end_n = 0;
    done_seen = 1'b0;
    vdd_bad = 1'b0;
    for (int n = 2; n <= 1100; n++) begin
      cyc(0, 0, 0, (((n - 1) / 2) % 2 == 0) ? 'h5100 : 'h4F00);
      if (done) done_seen = 1'b1;
      if (!busy) begin
        end_n = n;
        break;
      end
      if (vdd_sel != 2'd3 || freq_sel != 2'd1 || uv_alarm) vdd_bad = 1'b1;
    end
    chk("tmo exit cycle", 16'(end_n), 16'd1025);
    chk("tmo hold during wait", 16'(vdd_bad), 16'd0);
    chk("tmo no done", 16'(done_seen), 16'd0);
    chk("tmo vdd restored", 16'(vdd_sel), 16'd1);
    chk("tmo freq kept", 16'(freq_sel), 16'd1);
    chk("tmo cur_level", 16'(cur_level), 16'd1);
    chk("tmo err_timeout", 16'(err_timeout), 16'd1);

    // Request 1 -> 2, then keep req_valid high with changing levels while busy.
    cyc(0, 1, 2, 'h4800);
    chk("busy accept vdd_sel", 16'(vdd_sel), 16'd2);
    chk("busy accept ready", 16'(req_ready), 16'd0);
    chk("busy err cleared", 16'(err_timeout), 16'd0);
    done_n = 0;
    for (int n = 2; n <= 20; n++) begin
      cyc(0, 1, n % 4, 'h4800);
      if (done) begin
        done_n = n;
        break;
      end
      chk($sformatf("busy n%0d ready", n), 16'(req_ready), 16'd0);
      chk($sformatf("busy n%0d vdd_sel", n), 16'(vdd_sel), 16'd2);
      chk($sformatf("busy n%0d freq_sel", n), 16'(freq_sel), 16'd1);
    end
    chk("busy done cycle", 16'(done_n), 16'd5);
    chk("busy freq_sel", 16'(freq_sel), 16'd2);
    chk("busy cur_level", 16'(cur_level), 16'd2);
    cyc(0, 0, 0, 'h4800);
    chk("busy idle after", 16'(busy), 16'd0);
    chk("busy idle cur", 16'(cur_level), 16'd2);
    chk("busy idle vdd", 16'(vdd_sel), 16'd2);

    // Lower 2 -> 0 and hit reset in the middle of F_SETTLE.
    cyc(0, 1, 0, 'h4800);
    chk("rst_fs freq_sel", 16'(freq_sel), 16'd0);
    chk("rst_fs vdd_sel", 16'(vdd_sel), 16'd2);
    cyc(0, 0, 0, 'h4800);
    cyc(0, 0, 0, 'h4800);
    cyc(1, 0, 0, 'h4800);
    chk("rst_fs vdd_sel reset", 16'(vdd_sel), 16'd0);
    chk("rst_fs freq_sel reset", 16'(freq_sel), 16'd0);
    chk("rst_fs cur_level reset", 16'(cur_level), 16'd0);
    chk("rst_fs busy reset", 16'(busy), 16'd0);
    chk("rst_fs ready reset", 16'(req_ready), 16'd1);
    chk("rst_fs done reset", 16'(done), 16'd0);
    chk("rst_fs err reset", 16'(err_timeout), 16'd0);
    chk("rst_fs uv reset", 16'(uv_alarm), 16'd0);
    done_seen = 1'b0;
    busy_seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      cyc(0, 0, 0, 'h4800);
      if (done) done_seen = 1'b1;
      if (busy || vdd_sel != 2'd0) busy_seen = 1'b1;
    end
    chk("rst_fs no done after", 16'(done_seen), 16'd0);
    chk("rst_fs stays idle", 16'(busy_seen), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
